// File: rtl/i2c_slave_frame_reader.sv
// i2c_slave_frame_reader: sys_clk-synchronous I2C slave transmitter that buffers frames and streams them to a master read
// Ports: i_sys_clk, i_reset (async, active-high); i_slave_address bus address; i_scl_in/i_sda_in raw bus lines;
//        o_sda_oe open-drain pull-down enable; i_frame_data/i_frame_valid/o_frame_ready frame push side;
//        o_fifo_level frames stored; o_frames_sent delivered frames; o_overrun/o_underrun sticky errors; o_busy addressed transfer.
module i2c_slave_frame_reader #(
  parameter int FRAME_BYTES    = 6,
  parameter int DEPTH          = 4,
  parameter int FILT_LEN       = 3,
  parameter int HOLD_CYCLES    = 2,
  parameter bit LSB_BYTE_FIRST = 1
) (
  input  logic                     i_sys_clk,
  input  logic                     i_reset,
  input  logic [6:0]               i_slave_address,
  input  logic                     i_scl_in,
  input  logic                     i_sda_in,
  output logic                     o_sda_oe,
  input  logic [8*FRAME_BYTES-1:0] i_frame_data,
  input  logic                     i_frame_valid,
  output logic                     o_frame_ready,
  output logic [$clog2(DEPTH):0]   o_fifo_level,
  output logic [15:0]              o_frames_sent,
  output logic                     o_overrun,
  output logic                     o_underrun,
  output logic                     o_busy
);
  localparam int FW = 8 * FRAME_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(FRAME_BYTES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, TX_BYTE, WAIT_MACK, IGNORE} state_t;

  logic [1:0]          r_scl_sync, r_sda_sync;
  logic [FILT_LEN-1:0] r_scl_hist, r_sda_hist;
  logic                r_scl_f, r_sda_f, r_scl_d, r_sda_d;

  // A line level is accepted only after FILT_LEN identical synchronised samples.
  always_ff @(posedge i_sys_clk or posedge i_reset)
    if (i_reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= '1;
      r_sda_hist <= '1;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl_in};
      r_sda_sync <= {r_sda_sync[0], i_sda_in};
      r_scl_hist <= FILT_LEN'({r_scl_hist, r_scl_sync[1]});
      r_sda_hist <= FILT_LEN'({r_sda_hist, r_sda_sync[1]});
      r_scl_f    <= &r_scl_hist ? 1'b1 : |r_scl_hist ? r_scl_f : 1'b0;
      r_sda_f    <= &r_sda_hist ? 1'b1 : |r_sda_hist ? r_sda_f : 1'b0;
      r_scl_d    <= r_scl_f;
      r_sda_d    <= r_sda_f;
    end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = r_scl_f & ~r_scl_d;
  assign w_scl_fall = ~r_scl_f & r_scl_d;
  // SCL must be high on both samples so an SDA change coincident with an SCL edge is not a bus condition.
  assign w_start    = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
  assign w_stop     = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;

  logic [FW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overrun;
  logic          w_full, w_empty, w_push, w_pop;
  logic [FW-1:0] w_head;

  assign w_full  = r_level == LW'(DEPTH);
  assign w_empty = r_level == '0;
  // A pop frees the head slot in the same cycle, so a push is still taken when full.
  assign w_push  = i_frame_valid & (~w_full | w_pop);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_sys_clk)
    if (w_push) r_mem[r_wr_ptr] <= i_frame_data;

  always_ff @(posedge i_sys_clk or posedge i_reset)
    if (i_reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + AW'(w_push);
      r_rd_ptr  <= r_rd_ptr + AW'(w_pop);
      r_level   <= r_level + LW'(w_push) - LW'(w_pop);
      r_overrun <= r_overrun | (i_frame_valid & w_full & ~w_pop);
    end

  state_t        r_state, w_state_nx;
  logic [3:0]    r_bit_cnt, w_bit_cnt_nx;
  logic [6:0]    r_shift, w_shift_nx;
  logic          r_match, w_match_nx;
  logic [FW-1:0] r_frame, w_frame_nx;
  logic [BW-1:0] r_byte_idx, w_byte_idx_nx;
  logic          r_filler, w_filler_nx;
  logic          r_reload, w_reload_nx;
  logic          r_busy, w_busy_nx;
  logic [15:0]   r_frames_sent, w_frames_sent_nx;
  logic          r_underrun, w_underrun_nx;
  logic          w_sched, w_sched_val;
  logic [7:0]    w_rx_byte, w_cur_byte, w_head_byte;
  logic          w_match, w_last;

  assign w_rx_byte   = {r_shift, r_sda_f};
  assign w_match     = (w_rx_byte[7:1] == i_slave_address) & w_rx_byte[0] & ~w_empty;
  assign w_cur_byte  = LSB_BYTE_FIRST ? r_frame[7:0] : r_frame[FW-1 -: 8];
  assign w_head_byte = LSB_BYTE_FIRST ? w_head[7:0] : w_head[FW-1 -: 8];
  assign w_last      = r_byte_idx == BW'(FRAME_BYTES - 1);

  always_ff @(posedge i_sys_clk or posedge i_reset)
    if (i_reset) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_match       <= 1'b0;
      r_frame       <= '0;
      r_byte_idx    <= '0;
      r_filler      <= 1'b0;
      r_reload      <= 1'b0;
      r_busy        <= 1'b0;
      r_frames_sent <= '0;
      r_underrun    <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_bit_cnt     <= w_bit_cnt_nx;
      r_shift       <= w_shift_nx;
      r_match       <= w_match_nx;
      r_frame       <= w_frame_nx;
      r_byte_idx    <= w_byte_idx_nx;
      r_filler      <= w_filler_nx;
      r_reload      <= w_reload_nx;
      r_busy        <= w_busy_nx;
      r_frames_sent <= w_frames_sent_nx;
      r_underrun    <= w_underrun_nx;
    end

  // Rises sample the bus, falls schedule the next SDA value (applied after the hold delay).
  always_comb begin
    w_state_nx       = r_state;
    w_bit_cnt_nx     = r_bit_cnt;
    w_shift_nx       = r_shift;
    w_match_nx       = r_match;
    w_frame_nx       = r_frame;
    w_byte_idx_nx    = r_byte_idx;
    w_filler_nx      = r_filler;
    w_reload_nx      = r_reload;
    w_busy_nx        = r_busy;
    w_frames_sent_nx = r_frames_sent;
    w_underrun_nx    = r_underrun;
    w_pop            = 1'b0;
    w_sched          = 1'b0;
    w_sched_val      = 1'b0;
    if (w_stop) begin
      w_state_nx = IDLE;
      w_busy_nx  = 1'b0;
    end else if (w_start) begin
      w_state_nx   = ADDR;
      w_bit_cnt_nx = '0;
      w_match_nx   = 1'b0;
      w_filler_nx  = 1'b0;
      w_reload_nx  = 1'b0;
    end else begin
      case (r_state)
        ADDR:
          if (w_scl_rise && !r_match) begin
            w_shift_nx   = w_rx_byte[6:0];
            w_bit_cnt_nx = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_match_nx = w_match;
              w_state_nx = w_match ? ADDR : IGNORE;
            end
          end else if (w_scl_fall && r_match) begin
            w_sched     = 1'b1;
            w_sched_val = 1'b1;
            w_state_nx  = ADDR_ACK;
          end
        ADDR_ACK:
          if (w_scl_fall) begin
            w_pop         = 1'b1;
            w_frame_nx    = w_head;
            w_byte_idx_nx = '0;
            w_bit_cnt_nx  = 4'd1;
            w_sched       = 1'b1;
            w_sched_val   = ~w_head_byte[7];
            w_busy_nx     = 1'b1;
            w_state_nx    = TX_BYTE;
          end
        TX_BYTE:
          if (w_scl_fall) begin
            w_sched = 1'b1;
            if (r_bit_cnt == 4'd8) begin
              w_sched_val = 1'b0;
              w_state_nx  = WAIT_MACK;
            end else if (r_reload) begin
              w_pop         = 1'b1;
              w_frame_nx    = w_head;
              w_byte_idx_nx = '0;
              w_bit_cnt_nx  = 4'd1;
              w_sched_val   = ~w_head_byte[7];
              w_reload_nx   = 1'b0;
            end else begin
              w_sched_val  = ~r_filler & ~w_cur_byte[~r_bit_cnt[2:0]];
              w_bit_cnt_nx = r_bit_cnt + 4'd1;
            end
          end
        WAIT_MACK:
          if (w_scl_rise) begin
            w_bit_cnt_nx = '0;
            if (r_sda_f) begin
              w_state_nx       = IGNORE;
              w_frames_sent_nx = r_frames_sent + 16'((w_last && !r_filler) ? 1 : 0);
            end else begin
              w_state_nx = TX_BYTE;
              if (!r_filler && !w_last) begin
                w_byte_idx_nx = r_byte_idx + BW'(1);
                w_frame_nx    = LSB_BYTE_FIRST ? r_frame >> 8 : r_frame << 8;
              end else if (!r_filler) begin
                w_frames_sent_nx = r_frames_sent + 16'd1;
                w_filler_nx      = w_empty;
                w_underrun_nx    = r_underrun | w_empty;
                w_reload_nx      = ~w_empty;
              end
            end
          end
        default: ;
      endcase
    end
  end

  logic [HW-1:0] r_hold;
  logic          r_pend, r_sda_oe;

  // SDA only moves while SCL is low, except for the forced release on START/STOP.
  always_ff @(posedge i_sys_clk or posedge i_reset)
    if (i_reset) begin
      r_hold   <= '0;
      r_pend   <= 1'b0;
      r_sda_oe <= 1'b0;
    end else if (w_start || w_stop) begin
      r_hold   <= '0;
      r_sda_oe <= 1'b0;
    end else if (w_sched) begin
      r_hold <= HW'(HOLD_CYCLES);
      r_pend <= w_sched_val;
      if (HOLD_CYCLES == 0) r_sda_oe <= w_sched_val;
    end else if (r_hold != '0) begin
      r_hold <= r_hold - HW'(1);
      if (r_hold == HW'(1) && !r_scl_f) r_sda_oe <= r_pend;
    end

  assign o_sda_oe      = r_sda_oe;
  assign o_frame_ready = ~w_full;
  assign o_fifo_level  = r_level;
  assign o_frames_sent = r_frames_sent;
  assign o_overrun     = r_overrun;
  assign o_underrun    = r_underrun;
  assign o_busy        = r_busy;
endmodule

// File: doc/i2c_slave_frame_reader.md
Name: i2c_slave_frame_reader

Overview:
- Parametrised, fully sys_clk-synchronous I2C slave transmitter for MCU read-out of filtered sample frames (CIC output words).
- Buffers up to DEPTH frames of FRAME_BYTES bytes in an internal FIFO, so the source never stalls on the bus.
- Answers master reads at slave_address with one or more whole frames; NACKs writes and reads when empty.
- No async edge logic: START/STOP are detected from oversampled SCL/SDA.

Parameters:
FRAME_BYTES, 6, bytes per frame; frame width = 8*FRAME_BYTES.
DEPTH, 4, FIFO depth in frames; power of two, >= 2.
FILT_LEN, 3, consecutive equal sys_clk samples needed to accept a new SCL/SDA level.
HOLD_CYCLES, 2, sys_clk delay from filtered SCL fall to sda_oe update.
LSB_BYTE_FIRST, 1, 1: frame byte 0 = frame_data[7:0] sent first; 0: most significant byte first. Bits within a byte are always MSB first.

Ports:
sys_clk  in  1  system clock, >= 20x SCL frequency
reset  in  1  asynchronous, active-high reset
slave_address  in  7  bus address, sampled at the 8th SCL rise of an address byte
scl_in  in  1  raw SCL
sda_in  in  1  raw SDA
sda_oe  out  1  1 = pull SDA low (open-drain); pad drives 'z' otherwise
frame_data  in  8*FRAME_BYTES  frame to enqueue
frame_valid  in  1  push request, one frame per cycle high
frame_ready  out  1  FIFO not full
fifo_level  out  $clog2(DEPTH)+1  frames stored
frames_sent  out  16  whole frames ACKed by the master, wraps at 65535->0
overrun  out  1  sticky: push attempted while full
underrun  out  1  sticky: master ACKed the last byte of a frame while the FIFO was empty
busy  out  1  high from addressed START to STOP

Behaviour:
- Reset values: sda_oe=0, frame_ready=1, fifo_level=0, frames_sent=0, overrun=0, underrun=0, busy=0, FSM=IDLE, FIFO empty.
- Input conditioning:
  - 2-flop synchroniser, then a FILT_LEN-sample filter per line.
  - SCL rise/fall = one-cycle strobes on filtered SCL.
  - START = filtered SDA 1->0 while filtered SCL=1.
  - STOP = filtered SDA 0->1 while filtered SCL=1.
  - A START seen in any state (repeated START) -> ADDR, bit counter cleared, sda_oe=0.
  - STOP in any state -> IDLE, sda_oe=0.
- FIFO:
  - Push when frame_valid && frame_ready.
  - Push while full: frame dropped, overrun<=1.
  - A pop and a push in the same cycle are both honoured; fifo_level is unchanged.
  - fifo_level and frame_ready update on the cycle after the push/pop.
- FSM states: IDLE, ADDR, ADDR_ACK, TX_BYTE, WAIT_MACK, IGNORE.
- ADDR:
  - Shift SDA on 8 SCL rises (7 address bits + R/W).
  - On the 8th rise, match = (addr == slave_address) && R/W==1 && fifo_level!=0.
  - match: on the next SCL fall, after HOLD_CYCLES, sda_oe<=1; go to ADDR_ACK.
  - No match (wrong address, write, or empty FIFO): go to IGNORE; sda_oe stays 0 (NACK).
- ADDR_ACK:
  - On the 9th SCL fall: pop the head frame into a shift register, byte_idx=0.
  - Drive bit 7 of the first byte (sda_oe = ~bit) after HOLD_CYCLES; busy<=1; go to TX_BYTE.
- TX_BYTE:
  - Each SCL fall presents the next bit.
  - After 8 bits, release SDA (sda_oe=0) on the 8th fall; go to WAIT_MACK.
- WAIT_MACK: master ACK/NACK is sampled on the 9th SCL rise.
  - NACK: go to IGNORE. If byte_idx != FRAME_BYTES-1, the partial frame is discarded, not re-queued, and frames_sent is unchanged.
  - ACK, not last byte: byte_idx+1, back to TX_BYTE.
  - ACK on last byte: frames_sent+1. If the FIFO is non-empty, pop the next frame at the next SCL fall and continue. If empty, set underrun<=1 and send 0xFF filler bytes (SDA released) until NACK/STOP.
  - frames_sent also increments when the last byte is NACKed; a whole frame was delivered.
- IGNORE: sda_oe=0; wait for START or STOP. busy follows the addressed transaction only.
- sda_oe never changes while filtered SCL=1, except being forced to 0 by STOP/START detection.
- Reset mid-transfer: immediate release of SDA, FIFO and counters cleared.

Test Plan:
- Push 1 frame 0x0605_0403_0201; read at addr 0x58, ACK 5 bytes, NACK 6th -> address ACK; bytes 01,02,03,04,05,06; frames_sent=1; fifo_level=0.
- Read addr 0x58 with FIFO empty -> address NACK (SDA high on 9th clock); no pop; underrun=0. Write to 0x58 -> NACK. Read to 0x59 -> NACK, sda_oe never asserted.
- Push 2 frames, read 12 bytes all ACKed, 13th ACKed -> both frames in order; frames_sent=2; 13th byte 0xFF; underrun=1.
- Master NACKs after byte 3, repeated START, read again -> first frame discarded; second read returns the next frame's byte 0; frames_sent counts only the completed frame.
- Push DEPTH+1 frames back-to-back with no reads -> frame_ready=0 after DEPTH pushes; overrun=1; fifo_level=DEPTH. Simultaneous push+pop when full -> level unchanged.
- SCL/SDA glitches shorter than FILT_LEN cycles and assertion of reset mid-byte -> no false START/STOP or bit shift; after reset, sda_oe=0 within the reset cycle and all outputs are at reset values.
